// File: rtl/tick_rate_controller_pkg.sv
// Shared types and constants for the key-driven tick rate controller.
// Used by the interface, the key debouncer and the controller top.
package tick_rate_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INC     = 3'd1,
    DEC     = 3'd2,
    ARM_DBL = 3'd3,
    ARM_HLV = 3'd4,
    CANCEL  = 3'd5
  } trc_state_e;

  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_DBL = 2;
  localparam int KEY_HLV = 3;

  // Bits needed to hold 0..n; never less than one bit.
  function automatic int cnt_width(input int unsigned n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_rate_controller_if.sv
// Board-side bundle of the tick rate controller: raw keys in, period/tick/status out.
// There is no valid/ready handshake: keys are level signals sampled every clock, and tick is a one-cycle strobe.
interface tick_rate_controller_if #(
  parameter int w_key    = 4,
  parameter int w_period = 32
) ();
  import tick_rate_pkg::*;

  logic [w_key-1:0]    key;
  logic [w_period-1:0] period;
  logic                tick;
  logic                at_min;
  logic                at_max;
  trc_state_e          dbg_state;

  modport master (
    output key,
    input  period, tick, at_min, at_max, dbg_state
  );

  modport slave (
    input  key,
    output period, tick, at_min, at_max, dbg_state
  );

endinterface

// File: rtl/tick_rate_controller_key_debounce.sv
// Single-key debouncer: two-flop synchronizer, then a stability counter.
// The level flips after debounce_cycles consecutive disagreeing samples; rise/fall strobe with the flip.
module key_debounce
  import tick_rate_pkg::*;
#(
  parameter int unsigned debounce_cycles = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(debounce_cycles);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(debounce_cycles - 1)) begin
        flip = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    level_d = level_q ^ flip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= flip & ~level_q;
      fall_q  <= flip & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/tick_rate_controller.sv
// Key gesture FSM, saturating period register and periodic tick generator for the hex counter lab.
// Build option: define TICK_RATE_CTRL_AUTOREPEAT_EN for accelerating inc/dec steps while a key is held.
module tick_rate_controller
  import tick_rate_pkg::*;
#(
  parameter int unsigned clk_mhz         = 50,
  parameter int          w_key           = 4,
  parameter int          w_period        = 32,
  parameter int unsigned min_period      = clk_mhz * 1000 * 1000 / 50,
  parameter int unsigned max_period      = clk_mhz * 1000 * 1000 * 3,
  parameter int unsigned debounce_cycles = clk_mhz * 1000 * 5,
  parameter int unsigned accel_cycles    = clk_mhz * 1000 * 100,
  parameter int unsigned max_step        = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  tick_rate_controller_if.slave   io
);

  localparam int unsigned WX = w_period + 1;
  localparam logic [w_period-1:0] MIN_P = w_period'(min_period);
  localparam logic [w_period-1:0] MAX_P = w_period'(max_period);
  localparam logic [w_period-1:0] RST_P = w_period'((min_period + max_period) / 2);
  localparam logic [w_period:0]   MIN_X = WX'(min_period);
  localparam logic [w_period:0]   MAX_X = WX'(max_period);

  logic [3:0] db, rise, fall;

  for (genvar i = 0; i < 4; i++) begin : g_db
    key_debounce #(
      .debounce_cycles(debounce_cycles)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_i  (io.key[i]),
      .level_o(db[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  trc_state_e          state_q, state_d;
  logic [w_period-1:0] period_q, period_d;
  logic [w_period-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [w_period-1:0] step;

`ifdef TICK_RATE_CTRL_AUTOREPEAT_EN
  localparam int AW = cnt_width(accel_cycles);
  localparam logic [w_period-1:0] STEP_MAX = w_period'(max_step);

  logic [AW-1:0]       accel_q, accel_d;
  logic [w_period-1:0] step_q, step_d;
  logic [w_period:0]   step_dbl;
  logic                holding;

  // Holding means staying in INC/DEC; any exit drops the step back to 1.
  assign holding  = ((state_q == INC) || (state_q == DEC)) && (state_d == state_q);
  assign step_dbl = {step_q, 1'b0};

  always_comb begin
    accel_d = '0;
    step_d  = w_period'(1);
    if (holding) begin
      if (accel_q == AW'(accel_cycles - 1)) begin
        step_d = (step_dbl > {1'b0, STEP_MAX}) ? STEP_MAX : step_dbl[w_period-1:0];
      end else begin
        accel_d = accel_q + AW'(1);
        step_d  = step_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accel_q <= '0;
      step_q  <= w_period'(1);
    end else begin
      accel_q <= accel_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = w_period'(1);
`endif

  // All period arithmetic is one bit wider so nothing wraps before clamping.
  logic [w_period:0]   p_x, step_x, inc_x, dbl_x;
  logic [w_period-1:0] hlv_p;
  logic [w_period-1:0] inc_val, dec_val, dbl_val, hlv_val;

  always_comb begin
    p_x     = {1'b0, period_q};
    step_x  = {1'b0, step};
    inc_x   = p_x + step_x;
    dbl_x   = {period_q, 1'b0};
    hlv_p   = period_q >> 1;
    inc_val = (inc_x > MAX_X) ? MAX_P : inc_x[w_period-1:0];
    dec_val = (p_x < (MIN_X + step_x)) ? MIN_P : (period_q - step);
    dbl_val = (dbl_x > MAX_X) ? MAX_P : dbl_x[w_period-1:0];
    hlv_val = (hlv_p < MIN_P) ? MIN_P : hlv_p;
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    case (state_q)
      IDLE: begin
        if (db[KEY_INC])       state_d = INC;
        else if (db[KEY_DEC])  state_d = DEC;
        else if (rise[KEY_DBL]) state_d = ARM_DBL;
        else if (rise[KEY_HLV]) state_d = ARM_HLV;
      end
      INC: begin
        period_d = inc_val;
        if (!db[KEY_INC]) state_d = IDLE;
      end
      DEC: begin
        period_d = dec_val;
        if (!db[KEY_DEC]) state_d = IDLE;
      end
      ARM_DBL: begin
        if (db[KEY_HLV]) begin
          state_d = CANCEL;
        end else if (!db[KEY_DBL]) begin
          period_d = dbl_val;
          state_d  = IDLE;
        end
      end
      ARM_HLV: begin
        if (db[KEY_DBL]) begin
          state_d = CANCEL;
        end else if (!db[KEY_HLV]) begin
          period_d = hlv_val;
          state_d  = IDLE;
        end
      end
      CANCEL: begin
        if (db == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The countdown reloads from the period register only at zero, so changes wait for the next reload.
  always_comb begin
    if (cnt_q == '0) begin
      cnt_d  = period_q - w_period'(1);
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q - w_period'(1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= RST_P;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign io.period    = period_q;
  assign io.tick      = tick_q;
  assign io.at_min    = (period_q == MIN_P);
  assign io.at_max    = (period_q == MAX_P);
  assign io.dbg_state = state_q;

  // Keys above index 3, fall strobes and build-dependent parameters are intentionally unused.
  logic unused_cfg;
  assign unused_cfg = (^io.key) ^ (^fall) ^ (accel_cycles == 0) ^ (max_step == 0) ^ (clk_mhz == 0);

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller with min_period=4, max_period=64, debounce_cycles=2.
module tb_tick_rate_controller;
  import tick_rate_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  tick_rate_controller_if #(.w_key(4), .w_period(32)) io ();

  tick_rate_controller #(
    .w_key          (4),
    .w_period       (32),
    .min_period     (4),
    .max_period     (64),
    .debounce_cycles(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    io.key = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hv[4];
    logic exp_tick;
    hv = '{17, 8, 4, 4};
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    io.key = '0;
    cycles(2);

    // 1: reset values and tick spacing
    check("rst_period", io.period, 32'd34);
    check("rst_tick", {31'd0, io.tick}, 32'd0);
    check("rst_at_min", {31'd0, io.at_min}, 32'd0);
    check("rst_at_max", {31'd0, io.at_max}, 32'd0);
    check("rst_state", 32'(io.dbg_state), 32'(IDLE));
    rst = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      exp_tick = (c == 1) || (c == 35) || (c == 69);
      check($sformatf("t1_tick_c%0d", c), {31'd0, io.tick}, {31'd0, exp_tick});
    end
    check("t1_period", io.period, 32'd34);

    // 2: double saturates at max
    do_reset();
    io.key[2] = 1'b1;
    cycles(10);
    io.key[2] = 1'b0;
    cycles(8);
    check("t2_period_a", io.period, 32'd64);
    check("t2_at_max_a", {31'd0, io.at_max}, 32'd1);
    io.key[2] = 1'b1;
    cycles(10);
    io.key[2] = 1'b0;
    cycles(8);
    check("t2_period_b", io.period, 32'd64);
    check("t2_at_max_b", {31'd0, io.at_max}, 32'd1);

    // 3: halve floors and saturates at min
    do_reset();
    for (int i = 0; i < 4; i++) begin
      io.key[3] = 1'b1;
      cycles(5);
      io.key[3] = 1'b0;
      cycles(8);
      check($sformatf("t3_period_%0d", i), io.period, 32'(hv[i]));
      check($sformatf("t3_at_min_%0d", i), {31'd0, io.at_min}, (i >= 2) ? 32'd1 : 32'd0);
    end

    // 4: one-cycle glitch is filtered
    do_reset();
    io.key[2] = 1'b1;
    cycles(1);
    io.key[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check($sformatf("t4_state_%0d", i), 32'(io.dbg_state), 32'(IDLE));
    end
    check("t4_period", io.period, 32'd34);

    // 5: double armed, then halve key cancels
    do_reset();
    io.key[2] = 1'b1;
    cycles(6);
    check("t5_arm_dbl", 32'(io.dbg_state), 32'(ARM_DBL));
    io.key[3] = 1'b1;
    cycles(6);
    check("t5_cancel", 32'(io.dbg_state), 32'(CANCEL));
    io.key = '0;
    cycles(8);
    check("t5_idle", 32'(io.dbg_state), 32'(IDLE));
    check("t5_period", io.period, 32'd34);

    // 6: hold inc for 10 debounced cycles; new period applies at the next reload
    do_reset();
    for (int c = 1; c <= 130; c++) begin
      @(posedge clk);
      #1;
      exp_tick = (c == 1) || (c == 35) || (c == 79) || (c == 123);
      check($sformatf("t6_tick_c%0d", c), {31'd0, io.tick}, {31'd0, exp_tick});
      if (c == 18) check("t6_state_inc", 32'(io.dbg_state), 32'(INC));
      if (c == 10) io.key[0] = 1'b1;
      if (c == 20) io.key[0] = 1'b0;
    end
    check("t6_period", io.period, 32'd44);
    check("t6_at_max", {31'd0, io.at_max}, 32'd0);

    // 7: reset mid-gesture drops the pending double
    do_reset();
    io.key[2] = 1'b1;
    cycles(6);
    check("t7_arm_dbl", 32'(io.dbg_state), 32'(ARM_DBL));
    rst = 1'b1;
    #1;
    check("t7_rst_state", 32'(io.dbg_state), 32'(IDLE));
    check("t7_rst_period", io.period, 32'd34);
    io.key = '0;
    cycles(1);
    rst = 1'b0;
    cycles(10);
    check("t7_period", io.period, 32'd34);
    check("t7_state", 32'(io.dbg_state), 32'(IDLE));

    // 8: hold dec for 5 debounced cycles
    do_reset();
    io.key[1] = 1'b1;
    cycles(5);
    io.key[1] = 1'b0;
    cycles(8);
    check("t8_period", io.period, 32'd29);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
